// File: rtl/branch_target_predictor_if.sv
// Fetch/decode side signals of the branch target predictor: the same-cycle
// lookup path and the resolved-branch update path.
interface branch_target_predictor_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              lk_valid;
  logic [ADDR_W-1:0] lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;

  modport master (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
    input  lk_hit, lk_taken, lk_target
  );

  modport slave (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
    output lk_hit, lk_taken, lk_target
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and
// saturating statistics counters; combinational lookup, single-edge update.
module branch_target_predictor #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_target_predictor_if.slave bus,
  input  logic                     stat_clr,
  output logic [STAT_W-1:0]        stat_lookups,
  output logic [STAT_W-1:0]        stat_hits,
  output logic [STAT_W-1:0]        stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic [CTR_W-1:0] upd_ctr;
  logic             unused_pc_lsbs;

  assign lk_idx  = bus.lk_pc[IDX_W+1:2];
  assign lk_tag  = bus.lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

  // Lookup sees only registered state, so a same-cycle update is not bypassed.
  always_comb begin
    bus.lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bus.lk_taken  = bus.lk_hit && ctr_q[lk_idx][CTR_W-1];
    bus.lk_target = bus.lk_hit ? target_q[lk_idx] : '0;
  end

  always_comb begin
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr = ctr_q[upd_idx];
    if (bus.upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr = upd_ctr + CTR_W'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr = upd_ctr - CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (bus.upd_valid && !upd_hit && bus.upd_taken) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload storage carries no reset; the valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (!rst && bus.upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr;
        if (bus.upd_taken) target_q[upd_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bus.upd_target;
        ctr_q[upd_idx]    <= CTR_WEAK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bus.lk_valid && stat_lookups != '1)
        stat_lookups <= stat_lookups + STAT_W'(1);
      if (bus.lk_valid && bus.lk_hit && stat_hits != '1)
        stat_hits <= stat_hits + STAT_W'(1);
      if (bus.upd_valid && (bus.upd_pred_taken != bus.upd_taken) && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end

endmodule
